// File: rtl/bcd_1.sv
// -----------------------------------------------------------------------------
// bcd_1 -- registered 4-bit code to seven-segment decoder.
//
// The code {A,B,C,D} (A = MSB) is decoded to segment drives a..g plus a
// decimal-point flag dp. Every output comes straight from a flop, so a new
// code shows up exactly one rising clk edge after it is applied.
//
// Parameters:
//   ACTIVE_LOW : 0 = segments/dp lit when 1; 1 = every output inverted
//                (common-anode display).
//   HEX_MODE   : 0 = codes 10-15 blank the digit and raise dp as an
//                invalid-code flag; 1 = codes 10-15 show glyphs A-F.
//
// Ports:
//   clk        : single clock, rising edge.
//   rst_n      : synchronous active-low reset; blanks the digit.
//   A, B, C, D : code bits 3..0.
//   a .. g     : segments (a top, b top-right, c bottom-right, d bottom,
//                e bottom-left, f top-left, g middle).
//   dp         : decimal point / invalid-code flag.
// -----------------------------------------------------------------------------
module bcd_1 #(
  parameter int unsigned ACTIVE_LOW = 0,
  parameter int unsigned HEX_MODE   = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic dp
);

  // Output polarity is a single XOR mask over {a..g,dp}.
  localparam logic [7:0] INV_MASK = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  // Bit order of the pattern vectors: {a,b,c,d,e,f,g,dp}.
  logic [3:0] code;
  logic [7:0] lit;
  logic [7:0] seg_d;
  logic [7:0] seg_q;

  assign code = {A, B, C, D};

  always_comb begin
    // NOTE: default first so every path assigns 'lit' and no latch is inferred.
    lit = 8'b0000_0000;
    unique case (code)
      4'd0:  lit = 8'b1111_1100;
      4'd1:  lit = 8'b0110_0000;
      4'd2:  lit = 8'b1101_1010;
      4'd3:  lit = 8'b1111_0010;
      4'd4:  lit = 8'b0110_0110;
      4'd5:  lit = 8'b1011_0110;
      4'd6:  lit = 8'b1011_1110;
      4'd7:  lit = 8'b1110_0000;
      4'd8:  lit = 8'b1111_1110;
      4'd9:  lit = 8'b1111_0110;
      4'd10: lit = (HEX_MODE != 0) ? 8'b1110_1110 : 8'b0000_0001;
      4'd11: lit = (HEX_MODE != 0) ? 8'b0011_1110 : 8'b0000_0001;
      4'd12: lit = (HEX_MODE != 0) ? 8'b1001_1100 : 8'b0000_0001;
      4'd13: lit = (HEX_MODE != 0) ? 8'b0111_1010 : 8'b0000_0001;
      4'd14: lit = (HEX_MODE != 0) ? 8'b1001_1110 : 8'b0000_0001;
      4'd15: lit = (HEX_MODE != 0) ? 8'b1000_1110 : 8'b0000_0001;
      default: lit = 8'b0000_0000;
    endcase
    seg_d = lit ^ INV_MASK;
  end

  // Reset wins over decode; the blank state is all-unlit after polarity.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for all sequential state.
    if (!rst_n) seg_q <= INV_MASK;
    else        seg_q <= seg_d;
  end

  assign {a, b, c, d, e, f, g, dp} = seg_q;

endmodule

// File: tb/tb_bcd_1.sv
// -----------------------------------------------------------------------------
// tb_bcd_1 -- directed self-checking bench for bcd_1.
//
// Three instances share the same stimulus: default parameters, HEX_MODE=1 and
// ACTIVE_LOW=1. Inputs change 1 time unit after a rising edge and outputs are
// sampled 1 time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_bcd_1;

  logic clk = 1'b0;
  logic rst_n;
  logic A, B, C, D;

  logic a0, b0, c0, d0, e0, f0, g0, dp0;
  logic a1, b1, c1, d1, e1, f1, g1, dp1;
  logic a2, b2, c2, d2, e2, f2, g2, dp2;

  int checks = 0;
  int errors = 0;

  // Hand-derived {a..g,dp} patterns, logical polarity.
  logic [7:0] dec_exp [16];
  logic [7:0] hex_exp [16];

  always #5 clk = ~clk;

  bcd_1 u_def (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0), .dp(dp0)
  );

  bcd_1 #(.HEX_MODE(1)) u_hex (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .dp(dp1)
  );

  bcd_1 #(.ACTIVE_LOW(1)) u_al (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2), .g(g2), .dp(dp2)
  );

  wire [7:0] out_def = {a0, b0, c0, d0, e0, f0, g0, dp0};
  wire [7:0] out_hex = {a1, b1, c1, d1, e1, f1, g1, dp1};
  wire [7:0] out_al  = {a2, b2, c2, d2, e2, f2, g2, dp2};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_code(input logic [3:0] n);
    {A, B, C, D} = n;
  endtask

  // Advance one rising edge, then step off it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    dec_exp[0]  = 8'b1111_1100; dec_exp[1]  = 8'b0110_0000;
    dec_exp[2]  = 8'b1101_1010; dec_exp[3]  = 8'b1111_0010;
    dec_exp[4]  = 8'b0110_0110; dec_exp[5]  = 8'b1011_0110;
    dec_exp[6]  = 8'b1011_1110; dec_exp[7]  = 8'b1110_0000;
    dec_exp[8]  = 8'b1111_1110; dec_exp[9]  = 8'b1111_0110;
    for (int i = 10; i < 16; i++) dec_exp[i] = 8'b0000_0001;
    for (int i = 0; i < 10; i++) hex_exp[i] = dec_exp[i];
    hex_exp[10] = 8'b1110_1110; hex_exp[11] = 8'b0011_1110;
    hex_exp[12] = 8'b1001_1100; hex_exp[13] = 8'b0111_1010;
    hex_exp[14] = 8'b1001_1110; hex_exp[15] = 8'b1000_1110;

    // Reset held for two edges with code 7 applied: outputs stay blank.
    rst_n = 1'b0;
    set_code(4'd7);
    #1;
    tick();
    check("rst_edge1_def", out_def, 8'b0000_0000);
    check("rst_edge1_hex", out_hex, 8'b0000_0000);
    check("rst_edge1_al",  out_al,  8'b1111_1111);
    tick();
    check("rst_edge2_def", out_def, 8'b0000_0000);
    check("rst_edge2_al",  out_al,  8'b1111_1111);

    // Release: first edge loads the decode of code 7.
    rst_n = 1'b1;
    tick();
    check("release_7_def", out_def, 8'b1110_0000);
    check("release_7_al",  out_al,  8'b0001_1111);

    // Sweep every code, one new code per clock.
    for (int n = 0; n < 16; n++) begin
      set_code(n[3:0]);
      tick();
      check($sformatf("sweep_def_%0d", n), out_def, dec_exp[n]);
      check($sformatf("sweep_hex_%0d", n), out_hex, hex_exp[n]);
      check($sformatf("sweep_al_%0d", n),  out_al,  ~dec_exp[n]);
    end

    // Explicit spot values.
    set_code(4'd1);
    tick();
    check("al_code1", out_al, 8'b1001_1111);

    // Latency: change 3 -> 5 between edges; output must wait for the edge.
    set_code(4'd3);
    tick();
    check("lat_3", out_def, 8'b1111_0010);
    set_code(4'd5);
    #3;
    check("lat_hold_3", out_def, 8'b1111_0010);
    tick();
    check("lat_5", out_def, 8'b1011_0110);

    // Reset mid-stream with code 6, then release with code 2.
    set_code(4'd6);
    tick();
    check("mid_6", out_def, 8'b1011_1110);
    rst_n = 1'b0;
    tick();
    check("mid_rst_def", out_def, 8'b0000_0000);
    check("mid_rst_al",  out_al,  8'b1111_1111);
    rst_n = 1'b1;
    set_code(4'd2);
    tick();
    check("mid_rel_2_def", out_def, 8'b1101_1010);
    check("mid_rel_2_hex", out_hex, 8'b1101_1010);

    // Back-to-back invalid/valid alternation in default mode.
    set_code(4'd12);
    tick();
    check("alt_12_def", out_def, 8'b0000_0001);
    check("alt_12_hex", out_hex, 8'b1001_1100);
    set_code(4'd9);
    tick();
    check("alt_9_def", out_def, 8'b1111_0110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
